// File: rtl/seven_segment_decoder.sv
// Monitors a 4-digit active-low multiplexed seven-segment bus and recovers the per-digit character codes.
// Optional input synchronizer enabled by defining SEG_DECODER_SYNC_EN.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       AN0,
  input  logic       AN1,
  input  logic       AN2,
  input  logic       AN3,
  input  logic       segA,
  input  logic       segB,
  input  logic       segC,
  input  logic       segD,
  input  logic       segE,
  input  logic       segF,
  input  logic       segG,
  input  logic       segDP,
  output logic [4:0] char0,
  output logic [4:0] char1,
  output logic [4:0] char2,
  output logic [4:0] char3,
  output logic [3:0] valid,
  output logic       change,
  output logic       frame_valid,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [11:0] bus_raw;
  logic [11:0] bus;
  logic [3:0]  an;
  logic [7:0]  pat;

  assign bus_raw = {AN3, AN2, AN1, AN0, segA, segB, segC, segD, segE, segF, segG, segDP};

`ifdef SEG_DECODER_SYNC_EN
  // Synchronizer flops idle at all-ones so reset looks like a dark, deselected bus.
  logic [11:0] sync1_q;
  logic [11:0] sync2_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus_raw;
      sync2_q <= sync1_q;
    end
  end

  assign bus = sync2_q;
`else
  assign bus = bus_raw;
`endif

  assign an  = bus[11:8];
  assign pat = bus[7:0];

  function automatic logic [4:0] decode(input logic [7:0] p);
    case (p)
      8'b00000011: decode = 5'd0;
      8'b10011111: decode = 5'd1;
      8'b00100101: decode = 5'd2;
      8'b00001101: decode = 5'd3;
      8'b10011001: decode = 5'd4;
      8'b01001001: decode = 5'd5;
      8'b01000001: decode = 5'd6;
      8'b00011111: decode = 5'd7;
      8'b00000001: decode = 5'd8;
      8'b00001001: decode = 5'd9;
      8'b11110101: decode = 5'd10;
      8'b00010001: decode = 5'd11;
      8'b01010111: decode = 5'd12;
      8'b11010101: decode = 5'd14;
      8'b11111110: decode = 5'd16;
      8'b11111111: decode = 5'd17;
      default:     decode = 5'd31;
    endcase
  endfunction

  function automatic logic [1:0] digit_idx(input logic [3:0] a);
    case (a)
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
  endfunction

  logic is_none;
  logic is_single;
  logic is_multi;

  assign is_none   = (an == 4'b1111);
  assign is_single = (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  assign is_multi  = !is_none && !is_single;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] ref_q, ref_d;
  logic [4:0]  char_q [4];
  logic [3:0]  valid_q;
  logic [3:0]  seen_q;
  logic        change_q;
  logic        fv_q;
  logic        err_q;

  logic        cap;
  logic [7:0]  cnt_inc;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_code;
  logic        cap_diff;
  logic [3:0]  seen_nx;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_single) begin
          ref_d = bus;
          if (STABLE_W == 8'd1) begin
            cap     = 1'b1;
            state_d = HOLD;
            cnt_d   = 8'd0;
          end else begin
            state_d = TRACK;
            cnt_d   = 8'd1;
          end
        end
      end
      TRACK: begin
        if (!is_single) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (bus == ref_q) begin
          if (cnt_inc >= STABLE_W) begin
            cap     = 1'b1;
            state_d = HOLD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          ref_d = bus;
          if (STABLE_W == 8'd1) begin
            cap     = 1'b1;
            state_d = HOLD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = 8'd1;
          end
        end
      end
      default: begin
        if (!is_single) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (bus != ref_q) begin
          ref_d = bus;
          if (STABLE_W == 8'd1) begin
            cap = 1'b1;
          end else begin
            state_d = TRACK;
            cnt_d   = 8'd1;
          end
        end
      end
    endcase
  end

  // Capture always uses the live sample; it equals the reference whenever cap is set.
  always_comb begin
    cap_idx  = digit_idx(an);
    cap_code = decode(pat);
    cap_diff = (cap_code != char_q[cap_idx]) || !valid_q[cap_idx];
    seen_nx  = seen_q | (4'b0001 << cap_idx);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      ref_q    <= '1;
      char_q   <= '{default: 5'd17};
      valid_q  <= 4'b0000;
      seen_q   <= 4'b0000;
      change_q <= 1'b0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      change_q <= 1'b0;
      fv_q     <= 1'b0;
      if (is_multi) begin
        err_q <= 1'b1;
      end
      if (cap) begin
        char_q[cap_idx]  <= cap_code;
        valid_q[cap_idx] <= 1'b1;
        change_q         <= cap_diff;
        if (seen_nx == 4'b1111) begin
          fv_q   <= 1'b1;
          seen_q <= 4'b0000;
        end else begin
          seen_q <= seen_nx;
        end
      end
    end
  end

  assign char0       = char_q[0];
  assign char1       = char_q[1];
  assign char2       = char_q[2];
  assign char3       = char_q[3];
  assign valid       = valid_q;
  assign change      = change_q;
  assign frame_valid = fv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder with STABLE_CYCLES = 4.
module tb_seven_segment_decoder;

`ifdef SEG_DECODER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = 4 + SYNC;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] an_n  = 4'hF;
  logic [7:0] seg_n = 8'hFF;
  logic [4:0] char0, char1, char2, char3;
  logic [3:0] valid;
  logic       change, frame_valid, err;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_cnt = 0;
  int fv_cnt = 0;

  localparam logic [7:0] P_R = 8'b11110101;
  localparam logic [7:0] P_A = 8'b00010001;
  localparam logic [7:0] P_M = 8'b01010111;
  localparam logic [7:0] P_N = 8'b11010101;

  seven_segment_decoder #(.STABLE_CYCLES(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .AN0(an_n[0]), .AN1(an_n[1]), .AN2(an_n[2]), .AN3(an_n[3]),
    .segA(seg_n[7]), .segB(seg_n[6]), .segC(seg_n[5]), .segD(seg_n[4]),
    .segE(seg_n[3]), .segF(seg_n[2]), .segG(seg_n[1]), .segDP(seg_n[0]),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3),
    .valid(valid), .change(change), .frame_valid(frame_valid), .err(err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic drive(input logic [3:0] a, input logic [7:0] p);
    an_n  = a;
    seg_n = p;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
      chg_cnt += int'(change);
      fv_cnt  += int'(frame_valid);
    end
  endtask

  task automatic clr_counts();
    chg_cnt = 0;
    fv_cnt  = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive(4'hF, 8'hFF);
    tick(2);
    n_cmp++; if ({char3, char2, char1, char0} !== {4{5'd17}}) begin n_bad++; $display("FAIL reset_chars got %h want %h", {char3, char2, char1, char0}, {4{5'd17}}); end
    n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid got %b want 0000", valid); end
    n_cmp++; if ({change, frame_valid, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {change, frame_valid, err}); end
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic test_stability();
    clr_counts();
    drive(4'b1110, 8'b00000011);
    tick(LAT - 1);
    n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL early_capture valid got %b want 0000", valid); end
    tick(1);
    n_cmp++; if (char0 !== 5'd0) begin n_bad++; $display("FAIL stab_char0 got %0d want 0", char0); end
    n_cmp++; if (valid !== 4'b0001) begin n_bad++; $display("FAIL stab_valid got %b want 0001", valid); end
    n_cmp++; if (change !== 1'b1) begin n_bad++; $display("FAIL stab_change got %b want 1", change); end
    tick(1);
    n_cmp++; if (change !== 1'b0) begin n_bad++; $display("FAIL change_width got %b want 0", change); end
    drive(4'hF, 8'hFF);
    tick(1 + SYNC);
    clr_counts();
    drive(4'b1110, 8'b10011111);
    tick(3);
    drive(4'hF, 8'hFF);
    tick(LAT);
    n_cmp++; if (char0 !== 5'd0) begin n_bad++; $display("FAIL short_dwell char0 got %0d want 0", char0); end
    n_cmp++; if (chg_cnt !== 0) begin n_bad++; $display("FAIL short_dwell changes got %0d want 0", chg_cnt); end
  endtask

  task automatic test_reset_midtrack();
    drive(4'b1101, 8'b00100101);
    tick(2 + SYNC);
    RESET = 1'b1;
    #1;
    n_cmp++; if ({char3, char2, char1, char0} !== {4{5'd17}}) begin n_bad++; $display("FAIL midreset_chars got %h want %h", {char3, char2, char1, char0}, {4{5'd17}}); end
    n_cmp++; if ({valid, change, frame_valid, err} !== 7'b0) begin n_bad++; $display("FAIL midreset_flags got %b want 0000000", {valid, change, frame_valid, err}); end
    drive(4'hF, 8'hFF);
    tick(2);
    RESET = 1'b0;
    tick(3);
  endtask

  task automatic scan_frame();
    logic [3:0] a_tab [4];
    logic [7:0] p_tab [4];
    a_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    p_tab = '{P_R, P_A, P_M, P_N};
    for (int i = 0; i < 4; i++) begin
      drive(a_tab[i], p_tab[i]);
      tick(8);
    end
    drive(4'hF, 8'hFF);
    tick(2);
  endtask

  task automatic test_full_frame();
    clr_counts();
    scan_frame();
    n_cmp++; if ({char3, char2, char1, char0} !== {5'd10, 5'd11, 5'd12, 5'd14}) begin n_bad++; $display("FAIL frame_chars got %h want %h", {char3, char2, char1, char0}, {5'd10, 5'd11, 5'd12, 5'd14}); end
    n_cmp++; if (chg_cnt !== 4) begin n_bad++; $display("FAIL frame_changes got %0d want 4", chg_cnt); end
    n_cmp++; if (fv_cnt !== 1) begin n_bad++; $display("FAIL frame_valid_count got %0d want 1", fv_cnt); end
    n_cmp++; if (valid !== 4'b1111) begin n_bad++; $display("FAIL frame_valid_mask got %b want 1111", valid); end
  endtask

  task automatic test_back_to_back();
    clr_counts();
    scan_frame();
    n_cmp++; if (fv_cnt !== 1) begin n_bad++; $display("FAIL repeat_frame_valid got %0d want 1", fv_cnt); end
    n_cmp++; if (chg_cnt !== 0) begin n_bad++; $display("FAIL repeat_changes got %0d want 0", chg_cnt); end
  endtask

  task automatic test_special();
    clr_counts();
    drive(4'b1101, 8'b11111110);
    tick(8);
    n_cmp++; if (char1 !== 5'd16) begin n_bad++; $display("FAIL period_char1 got %0d want 16", char1); end
    drive(4'b1101, 8'b01111111);
    tick(8);
    n_cmp++; if (char1 !== 5'd31) begin n_bad++; $display("FAIL unknown_char1 got %0d want 31", char1); end
    n_cmp++; if (chg_cnt !== 2) begin n_bad++; $display("FAIL special_changes got %0d want 2", chg_cnt); end
  endtask

  task automatic test_multi_anode();
    drive(4'hF, 8'hFF);
    tick(3);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_before got %b want 0", err); end
    clr_counts();
    drive(4'b1010, 8'b00000011);
    tick(10);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL multi_err got %b want 1", err); end
    n_cmp++; if (chg_cnt !== 0 || char0 !== 5'd14 || char2 !== 5'd11) begin n_bad++; $display("FAIL multi_nocapture changes %0d char0 %0d char2 %0d want 0 14 11", chg_cnt, char0, char2); end
    drive(4'hF, 8'hFF);
    tick(3);
    drive(4'b1110, 8'b10011111);
    tick(8);
    n_cmp++; if (char0 !== 5'd1) begin n_bad++; $display("FAIL after_err_char0 got %0d want 1", char0); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_stability();
    test_reset_midtrack();
    test_full_frame();
    test_back_to_back();
    test_special();
    test_multi_anode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

- Receive-side counterpart of the seven-segment character encoder.
- Samples a 4-digit, time-multiplexed, active-low seven-segment bus (anodes plus segments) and qualifies each digit's pattern over a stability window.
- Decodes each pattern back to the encoder's 5-bit character code and holds the result per digit position.
- Used for board-to-board loopback checking of display output and as a self-check monitor in simulation.

## Interface

- `STABLE_CYCLES`, default 4: consecutive identical samples (same single anode, same pattern) required before a capture; legal range 1..255.

- `CLOCK` in 1: system clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `AN0`, `AN1`, `AN2`, `AN3` in 1 each: digit anodes, active-low; `ANn` selects digit n.
- `segA`, `segB`, `segC`, `segD`, `segE`, `segF`, `segG`, `segDP` in 1 each: segments, active-low.
- `char0`, `char1`, `char2`, `char3` out 5 each: last captured code for digit 0..3.
- `valid` out 4: bit n set once `charn` has been captured since reset.
- `change` out 1: one-cycle pulse when a capture writes a value different from the stored one.
- `frame_valid` out 1: one-cycle pulse when all four digits have been captured since the previous pulse.
- `err` out 1: sticky flag, set when more than one anode is low in a sample.

## Operation

**Decode map.** Pattern bits are {A,B,C,D,E,F,G,DP}, where 0 means the segment is lit.

| Pattern | Code |
|---|---|
| 00000011 | 0 |
| 10011111 | 1 |
| 00100101 | 2 |
| 00001101 | 3 |
| 10011001 | 4 |
| 01001001 | 5 |
| 01000001 | 6 |
| 00011111 | 7 |
| 00000001 | 8 |
| 00001001 | 9 |
| 11110101 | 10 (R) |
| 00010001 | 11 (A) |
| 01010111 | 12 (M) |
| 11010101 | 14 (N) |
| 11111110 | 16 (period) |
| 11111111 | 17 (blank) |
| any other | 31 (unknown) |

**Sample.** Each cycle's sample is {anodes, pattern}. It is classified as one of:
- none: all anodes high.
- single: exactly one anode low.
- multi: two or more anodes low.

**FSM.**
- IDLE
  - single → TRACK, with `cnt` = 1 and the sample stored as the reference.
  - multi → set `err`, stay in IDLE.
- TRACK
  - Sample equals the reference → `cnt` + 1.
  - Different single sample → reference replaced, `cnt` = 1.
  - none → IDLE.
  - multi → IDLE and set `err`.
  - When `cnt` reaches `STABLE_CYCLES` → capture, then go to HOLD.
- HOLD
  - Sample equals the reference → stay in HOLD; no re-capture and no counting.
  - Different single sample → TRACK, `cnt` = 1.
  - none → IDLE.
  - multi → IDLE and set `err`.

**Capture for digit n.**
- Write the decoded code to `charn`.
- Set `valid[n]`.
- Pulse `change` if the code differs from the old `charn` or `valid[n]` was 0.
- Set bit n of the internal `seen` mask.

**Frame completion.** If `seen`, including the current capture, equals 4'b1111:
- pulse `frame_valid` on the same edge;
- clear `seen` to 0 on the same edge.

**Counter.** `cnt` is 8 bits wide and never wraps; it is reset to 1 or 0 on every state change.

**`err`.** Cleared only by `RESET`. Setting `err` never blocks later captures.

**With `STABLE_CYCLES` = 1.** Every new single sample captures on its first edge.

## Timing

**Reset values** (all asynchronous, immediate):

| Signal | Value |
|---|---|
| `char0`..`char3` | 5'd17 |
| `valid` | 4'b0000 |
| `change` | 0 |
| `frame_valid` | 0 |
| `err` | 0 |
| FSM | IDLE |
| `cnt` | 0 |
| `seen` | 0 |

- **Capture latency, without the sync macro:** if a constant single sample is first present at edge k, the capture happens at edge k+`STABLE_CYCLES`−1, and `charn`, `valid`, `change` and `frame_valid` are visible after that edge.
- **With `SEG_DECODER_SYNC_EN`:** add 2 edges to the latency above.
- **Pulse width:** `change` and `frame_valid` are exactly one cycle wide per capture.
- **Dwell shorter than `STABLE_CYCLES`:** no capture; the previous `charn` is retained.
- **Reset mid-TRACK:** the partial count is discarded and outputs return to their reset values immediately.

## Configuration

- **`SEG_DECODER_SYNC_EN` defined:**
  - All 12 bus inputs pass through a two-flop synchronizer, reset to 1 (inactive), before classification.
  - Capture latency increases by 2 cycles.
- **`SEG_DECODER_SYNC_EN` undefined:**
  - Inputs are classified directly and must be synchronous to `CLOCK`.
  - No added latency.

## Test plan

1. **Reset:** assert `RESET` mid-run → immediately all chars = 17, `valid` = 0, `err` = 0, no pulses.
2. **Stability window** (`STABLE_CYCLES` = 4, no sync):
   - `AN0` low, pattern 00000011, held for 4 edges → `char0` = 0, `valid` = 0001, one `change` pulse at the 4th edge.
   - Same pattern held for only 3 edges → no capture.
3. **Full frame:** scan `AN3`..`AN0` presenting R, A, M, N with 8 cycles each → chars {3..0} = {10,11,12,14}, four `change` pulses, exactly one `frame_valid` pulse at the 4th capture.
4. **Repeated frame:** re-scan the identical frame → `frame_valid` pulses again, no `change` pulses.
5. **Special patterns:** 11111110 on `AN1` → `char1` = 16; 01111111 → `char1` = 31.
6. **Multi-anode error:** `AN0` and `AN2` low together for 10 cycles → `err` = 1, no capture.
   - A following valid digit still captures.
   - With `SEG_DECODER_SYNC_EN`, case 2 captures at the 6th edge.
